// File: rtl/pr_timer.sv
// Memory-mapped down-counting timer with CTRL/PRESET/COUNT registers.
// Supports one-shot mode (sets a sticky pending flag) and auto-reload mode (pulses irq).
module pr_timer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] PrAddr,
  input  logic        PrWE,
  input  logic        sel,
  input  logic [3:0]  PrBE,
  input  logic [31:0] PrWD,
  output logic [31:0] PrRD,
  output logic        irq
);

  typedef enum logic [1:0] {StIdle, StLoad, StCnt, StInt} timerState_e;

  timerState_e stateQ, stateD;
  logic        enQ, enD;
  logic [1:0]  modeQ, modeD;
  logic        imQ, imD;
  logic        pendQ, pendD;
  logic [31:0] presetQ, presetD;
  logic [31:0] countQ, countD;

  logic wrCtrl, wrPreset, autoInt;

  assign wrCtrl   = sel & PrWE & (PrAddr[3:2] == 2'd0);
  assign wrPreset = sel & PrWE & (PrAddr[3:2] == 2'd1);
  assign autoInt  = (stateQ == StInt) && (modeQ == 2'b01);

  always_comb begin
    stateD  = stateQ;
    enD     = enQ;
    modeD   = modeQ;
    imD     = imQ;
    pendD   = pendQ;
    presetD = presetQ;
    countD  = countQ;

    unique case (stateQ)
      StIdle: if (enQ) stateD = StLoad;
      StLoad: begin
        countD = presetQ;
        stateD = StCnt;
      end
      StCnt: begin
        if (!enQ) begin
          stateD = StIdle;
        end else if (countQ == 32'd0) begin
          stateD = StInt;
        end else begin
          countD = countQ - 32'd1;
        end
      end
      StInt: begin
        if (modeQ == 2'b01) begin
          stateD = StLoad;
        end else begin
          pendD  = 1'b1;
          enD    = 1'b0;
          stateD = StIdle;
        end
      end
      default: stateD = StIdle;
    endcase

    // Bus writes are applied last so they override FSM updates to EN and PEND.
    if (wrCtrl) begin
      pendD = 1'b0;
      if (PrBE[0]) {imD, modeD, enD} = PrWD[3:0];
    end
    if (wrPreset) begin
      pendD = 1'b0;
      for (int i = 0; i < 4; i++) begin
        if (PrBE[i]) presetD[8*i +: 8] = PrWD[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ  <= StIdle;
      enQ     <= 1'b0;
      modeQ   <= 2'b00;
      imQ     <= 1'b0;
      pendQ   <= 1'b0;
      presetQ <= 32'd0;
      countQ  <= 32'd0;
    end else begin
      stateQ  <= stateD;
      enQ     <= enD;
      modeQ   <= modeD;
      imQ     <= imD;
      pendQ   <= pendD;
      presetQ <= presetD;
      countQ  <= countD;
    end
  end

  always_comb begin
    PrRD = 32'd0;
    case (PrAddr[3:2])
      2'd0:    PrRD = {27'd0, pendQ, imQ, modeQ, enQ};
      2'd1:    PrRD = presetQ;
      2'd2:    PrRD = countQ;
      default: PrRD = 32'd0;
    endcase
  end

  assign irq = imQ & (pendQ | autoInt);

  logic unusedAddr;
  assign unusedAddr = ^{PrAddr[31:4], PrAddr[1:0]};

endmodule

// File: tb/tb_pr_timer.sv
// Self-checking bench for pr_timer: directed scenarios with fixed expectations,
// then randomized bus traffic compared against a behavioural model every cycle.
module tb_pr_timer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] PrAddr;
  logic        PrWE;
  logic        sel;
  logic [3:0]  PrBE;
  logic [31:0] PrWD;
  logic [31:0] PrRD;
  logic        irq;

  pr_timer dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .PrAddr (PrAddr),
    .PrWE   (PrWE),
    .sel    (sel),
    .PrBE   (PrBE),
    .PrWD   (PrWD),
    .PrRD   (PrRD),
    .irq    (irq)
  );

  always #10 clk = ~clk;

  int nChecks = 0;
  int nPass   = 0;

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  // Behavioural model: phase of the timer plus architectural registers.
  localparam int PhIdle = 0, PhLoad = 1, PhCnt = 2, PhInt = 3;
  int          mPhase;
  logic        mEn, mIm, mPend;
  logic [1:0]  mMode;
  logic [31:0] mPreset, mCount;

  function automatic void modelReset();
    mPhase = PhIdle; mEn = 0; mIm = 0; mPend = 0; mMode = 0; mPreset = 0; mCount = 0;
  endfunction

  function automatic void modelStep(input logic s, input logic we, input logic [1:0] a,
                                    input logic [3:0] be, input logic [31:0] wd);
    int nextPhase = mPhase;
    if (mPhase == PhIdle) begin
      if (mEn) nextPhase = PhLoad;
    end else if (mPhase == PhLoad) begin
      mCount = mPreset;
      nextPhase = PhCnt;
    end else if (mPhase == PhCnt) begin
      if (!mEn) nextPhase = PhIdle;
      else if (mCount == 0) nextPhase = PhInt;
      else mCount = mCount - 1;
    end else begin
      if (mMode == 2'b01) nextPhase = PhLoad;
      else begin
        mPend = 1; mEn = 0; nextPhase = PhIdle;
      end
    end
    mPhase = nextPhase;
    if (s && we && a == 2'd0) begin
      mPend = 0;
      if (be[0]) begin
        mEn = wd[0]; mMode = wd[2:1]; mIm = wd[3];
      end
    end
    if (s && we && a == 2'd1) begin
      mPend = 0;
      for (int i = 0; i < 4; i++) if (be[i]) mPreset[8*i +: 8] = wd[8*i +: 8];
    end
  endfunction

  function automatic logic [31:0] modelRead(input logic [1:0] a);
    case (a)
      2'd0:    return {27'd0, mPend, mIm, mMode, mEn};
      2'd1:    return mPreset;
      2'd2:    return mCount;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic modelIrq();
    return mIm & (mPend | (mPhase == PhInt && mMode == 2'b01));
  endfunction

  task automatic readReg(input logic [1:0] a, output logic [31:0] v);
    PrAddr = {28'd0, a, 2'b00};
    #1;
    v = PrRD;
  endtask

  task automatic compareAll();
    logic [31:0] v;
    for (int a = 0; a < 4; a++) begin
      readReg(a[1:0], v);
      checkEq($sformatf("model rd%0d", a), v, modelRead(a[1:0]));
    end
    checkEq("model irq", {31'd0, irq}, {31'd0, modelIrq()});
  endtask

  task automatic tick(input logic s, input logic we, input logic [1:0] a,
                      input logic [3:0] be, input logic [31:0] wd);
    sel = s; PrWE = we; PrAddr = {28'd0, a, 2'b00}; PrBE = be; PrWD = wd;
    @(posedge clk);
    modelStep(s, we, a, be, wd);
    #1;
    PrWE = 1'b0;
    compareAll();
  endtask

  task automatic idle();
    tick(1'b1, 1'b0, 2'd0, 4'h0, 32'd0);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] wd);
    tick(1'b1, 1'b1, a, 4'hF, wd);
  endtask

  initial begin
    logic [31:0] v;
    rst_n = 1'b0; PrAddr = 0; PrWE = 0; sel = 0; PrBE = 0; PrWD = 0;
    modelReset();
    #3;
    for (int a = 0; a < 4; a++) begin
      readReg(a[1:0], v);
      checkEq($sformatf("reset rd%0d", a), v, 32'd0);
    end
    checkEq("reset irq", {31'd0, irq}, 32'd0);
    #22 rst_n = 1'b1;

    // Byte lanes, ignored COUNT writes, ignored upper CTRL bits.
    tick(1'b1, 1'b1, 2'd1, 4'b0101, 32'hAABBCCDD);
    readReg(2'd1, v); checkEq("byte lane preset", v, 32'h00BB00DD);
    wr(2'd2, 32'h12345678);
    readReg(2'd2, v); checkEq("count write ignored", v, 32'd0);
    wr(2'd0, 32'hFFFFFFF0);
    readReg(2'd0, v); checkEq("ctrl upper ignored", v, 32'd0);
    tick(1'b0, 1'b1, 2'd1, 4'hF, 32'h55);
    readReg(2'd1, v); checkEq("unselected write", v, 32'h00BB00DD);

    // One-shot.
    wr(2'd1, 32'd3);
    wr(2'd0, 32'h9);
    idle();
    for (int n = 3; n >= 0; n--) begin
      idle();
      readReg(2'd2, v); checkEq($sformatf("oneshot count %0d", n), v, n);
    end
    idle();
    idle();
    readReg(2'd0, v); checkEq("oneshot ctrl", v, 32'h18);
    for (int i = 0; i < 3; i++) begin
      idle();
      checkEq("oneshot irq held", {31'd0, irq}, 32'd1);
    end
    wr(2'd0, 32'h8);
    checkEq("oneshot irq cleared", {31'd0, irq}, 32'd0);
    readReg(2'd0, v); checkEq("oneshot ctrl cleared", v, 32'h8);

    // Auto-reload: irq high after every fifth edge.
    wr(2'd1, 32'd2);
    wr(2'd0, 32'hB);
    for (int i = 1; i <= 16; i++) begin
      idle();
      checkEq($sformatf("reload irq %0d", i), {31'd0, irq}, {31'd0, (i % 5 == 0)});
    end
    readReg(2'd0, v); checkEq("reload pend", {31'd0, v[4]}, 32'd0);
    wr(2'd0, 32'h0);
    idle(); idle();

    // Disable at COUNT=6 then restart from PRESET.
    wr(2'd1, 32'd10);
    wr(2'd0, 32'h1);
    for (int i = 0; i < 5; i++) idle();
    wr(2'd0, 32'h0);
    readReg(2'd2, v); checkEq("disable count", v, 32'd6);
    idle(); idle(); idle();
    readReg(2'd2, v); checkEq("disable held", v, 32'd6);
    wr(2'd0, 32'h1);
    idle();
    idle();
    readReg(2'd2, v); checkEq("restart count", v, 32'd10);

    // Asynchronous reset mid-count, between edges.
    wr(2'd0, 32'h9);
    idle(); idle();
    #3 rst_n = 1'b0;
    modelReset();
    #1;
    for (int a = 0; a < 4; a++) begin
      readReg(a[1:0], v);
      checkEq($sformatf("async rst rd%0d", a), v, 32'd0);
    end
    checkEq("async rst irq", {31'd0, irq}, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      idle();
      checkEq("post reset irq", {31'd0, irq}, 32'd0);
    end

    // Bus write to CTRL wins against one-shot INT.
    wr(2'd1, 32'd1);
    wr(2'd0, 32'h9);
    for (int i = 0; i < 4; i++) idle();
    wr(2'd0, 32'h9);
    readReg(2'd0, v); checkEq("collision ctrl", v, 32'h9);
    checkEq("collision irq", {31'd0, irq}, 32'd0);
    idle();
    idle();
    readReg(2'd2, v); checkEq("collision restart", v, 32'd1);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic        s, we;
      logic [1:0]  a;
      logic [3:0]  be;
      logic [31:0] wd;
      s  = ($urandom_range(0, 7) != 0);
      we = ($urandom_range(0, 3) == 0);
      a  = 2'($urandom_range(0, 3));
      be = 4'($urandom_range(0, 15));
      wd = ($urandom_range(0, 7) == 0) ? $urandom() : 32'($urandom_range(0, 12));
      if (a == 2'd0 && $urandom_range(0, 1) == 1) be[0] = 1'b1;
      tick(s, we, a, be, wd);
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
